// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port (WE3/A3/WD3), shared by ALU and load results.
// Optional build macro REGFILE_ARB_RR_EN: round-robin between non-conflicting simultaneous requests.
module regfile_wb_arbiter #(
   parameter  int DATA_W    = 32,
   parameter  int ADDR_W    = 5,
   parameter  int BUF_DEPTH = 2,
   localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid_i,
   output logic              alu_ready_o,
   input  logic [ADDR_W-1:0] alu_rd_i,
   input  logic [DATA_W-1:0] alu_data_i,
   input  logic              ld_valid_i,
   output logic              ld_ready_o,
   input  logic [ADDR_W-1:0] ld_rd_i,
   input  logic [DATA_W-1:0] ld_data_i,
   input  logic [ADDR_W-1:0] rs1_i,
   input  logic [ADDR_W-1:0] rs2_i,
   output logic              rs_hazard_o,
   output logic              rf_we_o,
   output logic [ADDR_W-1:0] rf_waddr_o,
   output logic [DATA_W-1:0] rf_wdata_o,
   output logic [CNT_W-1:0]  buf_count_o
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] bufRd_q   [BUF_DEPTH];
   logic [ADDR_W-1:0] bufRd_d   [BUF_DEPTH];
   logic [DATA_W-1:0] bufData_q [BUF_DEPTH];
   logic [DATA_W-1:0] bufData_d [BUF_DEPTH];
   logic              rfWe_q, rfWe_d;
   logic [ADDR_W-1:0] rfAddr_q, rfAddr_d;
   logic [DATA_W-1:0] rfData_q, rfData_d;

   logic              ready;
   logic              aluAcc, ldAcc, bothAcc;
   logic              ldWins;
   logic              issueVld;
   logic [ADDR_W-1:0] issueRd;
   logic [DATA_W-1:0] issueData;
   logic              push0Vld, push1Vld;
   logic [ADDR_W-1:0] push0Rd, push1Rd;
   logic [DATA_W-1:0] push0Data, push1Data;
   logic [CNT_W-1:0]  base, base1;
   logic              hazard;

   assign ready   = (count_q < DEPTH_C);
   assign aluAcc  = alu_valid_i & ready & (alu_rd_i != '0);
   assign ldAcc   = ld_valid_i  & ready & (ld_rd_i  != '0);
   assign bothAcc = aluAcc & ldAcc;

`ifdef REGFILE_ARB_RR_EN
   logic rrLd_q, rrLd_d;

   // Same-register pairs always go to the load, since it is the older instruction.
   assign ldWins = (ld_rd_i == alu_rd_i) | rrLd_q;

   always_comb begin
      rrLd_d = rrLd_q;
      if ((count_q == '0) && bothAcc && (ld_rd_i != alu_rd_i)) begin
         rrLd_d = ~rrLd_q;
      end
   end
`else
   assign ldWins = 1'b1;
`endif

   always_comb begin
      issueVld  = 1'b0;
      issueRd   = '0;
      issueData = '0;
      push0Vld  = 1'b0;
      push0Rd   = '0;
      push0Data = '0;
      push1Vld  = 1'b0;
      push1Rd   = '0;
      push1Data = '0;
      if (count_q != '0) begin
         issueVld  = 1'b1;
         issueRd   = bufRd_q[0];
         issueData = bufData_q[0];
         push0Vld  = ldAcc | aluAcc;
         push0Rd   = ldAcc ? ld_rd_i   : alu_rd_i;
         push0Data = ldAcc ? ld_data_i : alu_data_i;
         push1Vld  = bothAcc;
         push1Rd   = alu_rd_i;
         push1Data = alu_data_i;
      end else if (bothAcc) begin
         issueVld  = 1'b1;
         push0Vld  = 1'b1;
         if (ldWins) begin
            issueRd   = ld_rd_i;
            issueData = ld_data_i;
            push0Rd   = alu_rd_i;
            push0Data = alu_data_i;
         end else begin
            issueRd   = alu_rd_i;
            issueData = alu_data_i;
            push0Rd   = ld_rd_i;
            push0Data = ld_data_i;
         end
      end else if (ldAcc) begin
         issueVld  = 1'b1;
         issueRd   = ld_rd_i;
         issueData = ld_data_i;
      end else if (aluAcc) begin
         issueVld  = 1'b1;
         issueRd   = alu_rd_i;
         issueData = alu_data_i;
      end
   end

   // Buffer is a shift FIFO: slot 0 is always the oldest entry, pushes land just above the survivors.
   always_comb begin
      bufRd_d   = bufRd_q;
      bufData_d = bufData_q;
      base      = (count_q != '0) ? (count_q - CNT_W'(1)) : count_q;
      base1     = base + CNT_W'(1);
      if (count_q != '0) begin
         for (int i = 0; i < BUF_DEPTH - 1; i++) begin
            bufRd_d[i]   = bufRd_q[i+1];
            bufData_d[i] = bufData_q[i+1];
         end
      end
      for (int i = 0; i < BUF_DEPTH; i++) begin
         if (push0Vld && (CNT_W'(i) == base)) begin
            bufRd_d[i]   = push0Rd;
            bufData_d[i] = push0Data;
         end
         if (push1Vld && (CNT_W'(i) == base1)) begin
            bufRd_d[i]   = push1Rd;
            bufData_d[i] = push1Data;
         end
      end
      count_d = base + CNT_W'(push0Vld) + CNT_W'(push1Vld);
   end

   always_comb begin
      rfWe_d   = issueVld;
      rfAddr_d = issueVld ? issueRd   : rfAddr_q;
      rfData_d = issueVld ? issueData : rfData_q;
   end

   // Hazard covers buffered writes plus the one currently presented to the register file.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
         if (CNT_W'(i) < count_q) begin
            if ((rs1_i != '0) && (rs1_i == bufRd_q[i])) hazard = 1'b1;
            if ((rs2_i != '0) && (rs2_i == bufRd_q[i])) hazard = 1'b1;
         end
      end
      if (rfWe_q) begin
         if ((rs1_i != '0) && (rs1_i == rfAddr_q)) hazard = 1'b1;
         if ((rs2_i != '0) && (rs2_i == rfAddr_q)) hazard = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         rfWe_q   <= 1'b0;
         rfAddr_q <= '0;
         rfData_q <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            bufRd_q[i]   <= '0;
            bufData_q[i] <= '0;
         end
`ifdef REGFILE_ARB_RR_EN
         rrLd_q   <= 1'b1;
`endif
      end else begin
         count_q  <= count_d;
         rfWe_q   <= rfWe_d;
         rfAddr_q <= rfAddr_d;
         rfData_q <= rfData_d;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            bufRd_q[i]   <= bufRd_d[i];
            bufData_q[i] <= bufData_d[i];
         end
`ifdef REGFILE_ARB_RR_EN
         rrLd_q   <= rrLd_d;
`endif
      end
   end

   assign alu_ready_o = ready;
   assign ld_ready_o  = ready;
   assign rs_hazard_o = hazard;
   assign rf_we_o     = rfWe_q;
   assign rf_waddr_o  = rfAddr_q;
   assign rf_wdata_o  = rfData_q;
   assign buf_count_o = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_regfile_wb_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 2;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              aluValid, ldValid;
   logic              aluReady, ldReady;
   logic [ADDR_W-1:0] aluRd, ldRd, rs1, rs2;
   logic [DATA_W-1:0] aluData, ldData;
   logic              rsHazard, rfWe;
   logic [ADDR_W-1:0] rfWaddr;
   logic [DATA_W-1:0] rfWdata;
   logic [CNT_W-1:0]  bufCount;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid_i(aluValid), .alu_ready_o(aluReady), .alu_rd_i(aluRd), .alu_data_i(aluData),
      .ld_valid_i(ldValid), .ld_ready_o(ldReady), .ld_rd_i(ldRd), .ld_data_i(ldData),
      .rs1_i(rs1), .rs2_i(rs2), .rs_hazard_o(rsHazard),
      .rf_we_o(rfWe), .rf_waddr_o(rfWaddr), .rf_wdata_o(rfWdata), .buf_count_o(bufCount)
   );

   typedef struct { logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data; } ent_t;
   typedef struct { logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data; int tag; } wr_t;
   typedef struct { logic ready; logic haz; } pre_t;

   ent_t pend[$];
   wr_t  wrQ[$];
   pre_t preQ[$];
   int   cntQ[$];

   bit                mInit = 1'b0;
   bit                mLastWe = 1'b0;
   logic [ADDR_W-1:0] mLastAddr = '0;
   bit                mFavorLd = 1'b1;
   int                errors = 0;
   int                checks = 0;
   int                edgeCnt = 0;

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edgeCnt, act, exp);
      end
   endtask

   function automatic bit hits(input logic [ADDR_W-1:0] r);
      if (r == '0) return 1'b0;
      foreach (pend[i]) if (pend[i].rd == r) return 1'b1;
      return mLastWe && (mLastAddr == r);
   endfunction

   // Drives one cycle of inputs and advances the model across the coming clock edge.
   task automatic applyStimulus(input bit r,
                                input bit aV, input logic [ADDR_W-1:0] aRd, input logic [DATA_W-1:0] aD,
                                input bit lV, input logic [ADDR_W-1:0] lRd, input logic [DATA_W-1:0] lD,
                                input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2);
      bit   rdy, aTake, lTake, haveIssue, ldFirst;
      ent_t iss, aEnt, lEnt;
      @(negedge clk);
      rst = r; aluValid = aV; aluRd = aRd; aluData = aD;
      ldValid = lV; ldRd = lRd; ldData = lD; rs1 = s1; rs2 = s2;
      if (mInit) preQ.push_back('{ready: (pend.size() < DEPTH), haz: (hits(s1) || hits(s2))});
      if (r) begin
         pend.delete();
         mLastWe = 1'b0;
         mFavorLd = 1'b1;
         mInit = 1'b1;
         cntQ.push_back(0);
         return;
      end
      rdy   = (pend.size() < DEPTH);
      aTake = aV && rdy && (aRd != '0);
      lTake = lV && rdy && (lRd != '0);
      aEnt  = '{rd: aRd, data: aD};
      lEnt  = '{rd: lRd, data: lD};
      haveIssue = 1'b0;
      iss = '{rd: '0, data: '0};
      if (pend.size() > 0) begin
         iss = pend.pop_front();
         haveIssue = 1'b1;
         if (lTake) pend.push_back(lEnt);
         if (aTake) pend.push_back(aEnt);
      end else if (lTake && aTake) begin
`ifdef REGFILE_ARB_RR_EN
         ldFirst = (lRd == aRd) || mFavorLd;
         if (lRd != aRd) mFavorLd = !mFavorLd;
`else
         ldFirst = 1'b1;
`endif
         haveIssue = 1'b1;
         iss = ldFirst ? lEnt : aEnt;
         pend.push_back(ldFirst ? aEnt : lEnt);
      end else if (lTake) begin
         haveIssue = 1'b1;
         iss = lEnt;
      end else if (aTake) begin
         haveIssue = 1'b1;
         iss = aEnt;
      end
      if (haveIssue) begin
         wrQ.push_back('{rd: iss.rd, data: iss.data, tag: edgeCnt + 1});
         mLastAddr = iss.rd;
      end
      mLastWe = haveIssue;
      cntQ.push_back(pend.size());
   endtask

   task automatic idle(input int n, input logic [ADDR_W-1:0] s1);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, '0, '0, s1, '0);
   endtask

   wr_t  mw;
   pre_t mp;
   int   mc;

   always begin
      @(posedge clk);
      #1;
      if (cntQ.size() > 0) begin
         mc = cntQ.pop_front();
         checkOutput("buf_count", 64'(bufCount), 64'(mc));
         if (rfWe === 1'b1) begin
            if (wrQ.size() == 0) begin
               checkOutput("spurious_write", 64'(1), 64'(0));
            end else begin
               mw = wrQ.pop_front();
               checkOutput("write_cycle", 64'(edgeCnt), 64'(mw.tag));
               checkOutput("rf_waddr", 64'(rfWaddr), 64'(mw.rd));
               checkOutput("rf_wdata", 64'(rfWdata), 64'(mw.data));
            end
         end else begin
            checkOutput("rf_we_known", 64'(rfWe), 64'(0));
            if (wrQ.size() > 0 && wrQ[0].tag <= edgeCnt) begin
               mw = wrQ.pop_front();
               checkOutput("missing_write", 64'(0), 64'(mw.rd));
            end
         end
      end
   end

   always begin
      @(negedge clk);
      #1;
      if (preQ.size() > 0) begin
         mp = preQ.pop_front();
         checkOutput("alu_ready", 64'(aluReady), 64'(mp.ready));
         checkOutput("ld_ready", 64'(ldReady), 64'(mp.ready));
         checkOutput("rs_hazard", 64'(rsHazard), 64'(mp.haz));
      end
   end

   initial begin
      rst = 1'b1; aluValid = 1'b0; ldValid = 1'b0;
      aluRd = '0; ldRd = '0; aluData = '0; ldData = '0; rs1 = '0; rs2 = '0;
      applyStimulus(1, 0, '0, '0, 0, '0, '0, '0, '0);
      applyStimulus(1, 0, '0, '0, 0, '0, '0, '0, '0);

      $display("[TB] reset with full buffer");
      applyStimulus(0, 1, 5'd1, 32'h1111_1111, 1, 5'd2, 32'h2222_2222, '0, '0);
      applyStimulus(0, 1, 5'd4, 32'h4444_4444, 1, 5'd6, 32'h6666_6666, 5'd4, 5'd6);
      applyStimulus(1, 1, 5'd8, 32'h8888_8888, 1, 5'd9, 32'h9999_9999, 5'd4, '0);
      idle(2, 5'd4);

      $display("[TB] single ALU write");
      applyStimulus(0, 1, 5'd5, 32'hA5A5_A5A5, 0, '0, '0, '0, '0);
      idle(2, 5'd5);

      $display("[TB] same-register pair");
      applyStimulus(0, 1, 5'd3, 32'hAAAA_0003, 1, 5'd3, 32'hBBBB_0003, '0, '0);
      idle(3, 5'd3);

      $display("[TB] sustained dual traffic");
      applyStimulus(0, 1, 5'd10, 32'h0000_00A0, 1, 5'd11, 32'h0000_00B0, '0, '0);
      applyStimulus(0, 1, 5'd12, 32'h0000_00A1, 1, 5'd13, 32'h0000_00B1, '0, '0);
      applyStimulus(0, 1, 5'd14, 32'h0000_00A2, 1, 5'd15, 32'h0000_00B2, '0, '0);
      idle(4, '0);

      $display("[TB] load to x0");
      applyStimulus(0, 0, '0, '0, 1, 5'd0, 32'hDEAD_BEEF, '0, '0);
      idle(2, '0);

      $display("[TB] hazard tracking");
      applyStimulus(0, 1, 5'd7, 32'h0000_0007, 1, 5'd9, 32'h0000_0009, 5'd7, '0);
      applyStimulus(0, 0, '0, '0, 0, '0, '0, 5'd7, 5'd9);
      applyStimulus(0, 0, '0, '0, 0, '0, '0, 5'd0, 5'd0);
      idle(3, 5'd7);

      $display("[TB] random traffic");
      for (int n = 0; n < 800; n++) begin
         applyStimulus(($urandom_range(0, 63) == 0),
                       ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                       ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                       $urandom,
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      idle(6, '0);
      @(posedge clk);
      #2;
      checkOutput("drain_empty", 64'(wrQ.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
